// File: rtl/ram_ctrl.sv
// ram_ctrl: request/response front end for a single-port RAM.
//
// The controller takes one read or write request at a time over a
// valid/ready handshake and drives the RAM strobe, address and write data.
// The RAM captures a write on the rising edge that ends WRITE. It updates
// read data on the falling edge in the middle of READ, and the controller
// registers that data on the rising edge that ends READ. Read data comes
// back on a valid/ready response channel. An 8-bit count of completed
// transactions wraps from 255 to 0.
//
// Build option:
//   RAM_CTRL_WACK_EN  When defined, a write also returns a response that
//                     echoes the written data. It then counts as complete
//                     at the response handshake, not at WRITE exit.
//
// Ports:
//   CLK_       in   clock, rising edge active
//   CLR_       in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  controller idle and able to accept
//   req_write  in   1 = write, 0 = read
//   req_addr   in   [ADDR_W] request address
//   req_data   in   [DATA_W] write data
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts response
//   rsp_data   out  [DATA_W] read data (or write echo)
//   mem_rw     out  RAM strobe, 1 = write
//   mem_addr   out  [ADDR_W] RAM address
//   mem_wdata  out  [DATA_W] RAM write data
//   mem_rdata  in   [DATA_W] RAM read data
//   txn_count  out  [8] completed transactions, modulo 256
module ram_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              CLK_,
  input  logic              CLR_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_done;

  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [7:0]        r_txn_count;

  // Next state, handshake strobes and completion pulse.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
`ifdef RAM_CTRL_WACK_EN
        w_next = RESP;
`else
        w_next = IDLE;
        w_done = 1'b1;
`endif
      end
      READ: begin
        w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_ or negedge CLR_) begin
    if (!CLR_) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The strobe is registered from the next state, so it is high only during
  // WRITE and drops on the same edge where the RAM captures the data.
  always_ff @(posedge CLK_ or negedge CLR_) begin
    if (!CLR_) begin
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_data  <= '0;
      r_txn_count <= '0;
    end else begin
      r_mem_rw <= (w_next == WRITE);
      if (w_accept) begin
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_data;
      end
      if (r_state == READ) begin
        r_rsp_data <= mem_rdata;
      end
`ifdef RAM_CTRL_WACK_EN
      if (r_state == WRITE) begin
        r_rsp_data <= r_mem_wdata;
      end
`endif
      if (w_done) begin
        r_txn_count <= r_txn_count + 8'd1;
      end
    end
  end

  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_data  = r_rsp_data;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized self-checking bench for ram_ctrl.
// The bench has a behavioural RAM on the memory port and a reference memory
// array with a transaction counter. Define RAM_CTRL_WACK_EN to check the
// write-acknowledge build.
module tb_ram_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK_;
  logic              CLR_;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        txn_count;

  ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .CLK_      (CLK_),
    .CLR_      (CLR_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .txn_count (txn_count)
  );

  initial CLK_ = 1'b0;
  always #5 CLK_ = ~CLK_;

  // Behavioural single-port RAM: write on rising edge, read on falling edge.
  logic [DATA_W-1:0] ram_arr [DEPTH];
  always @(posedge CLK_) if (mem_rw) ram_arr[mem_addr] <= mem_wdata;
  always @(negedge CLK_) mem_rdata <= ram_arr[mem_addr];

  // Reference state.
  int unsigned ref_mem [DEPTH];
  int unsigned exp_txn;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor: strobe never high two cycles in a row; accept spacing
  // during the burst phase.
  int unsigned cyc = 0;
  int unsigned rw_consec = 0;
  logic        prev_rw = 1'b0;
  bit          burst = 1'b0;
  int          last_acc = -1;
  int unsigned gap_bad = 0;
  int unsigned burst_acc = 0;
`ifdef RAM_CTRL_WACK_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 2;
`endif

  always @(negedge CLK_) begin
    cyc++;
    if (mem_rw && prev_rw) rw_consec++;
    prev_rw = mem_rw;
    if (burst && CLR_ && req_valid && req_ready) begin
      if (last_acc >= 0 && (int'(cyc) - last_acc) != EXP_GAP) gap_bad++;
      last_acc = int'(cyc);
      burst_acc++;
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge CLK_); #1;
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic hold_resp(input int stall, input logic [DATA_W-1:0] d);
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      @(posedge CLK_); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(d));
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_rw", 32'(mem_rw), 32'd0);
      check("stall_txn", 32'(txn_count), exp_txn);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_write(input int unsigned a, input int unsigned d, input int stall);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = ADDR_W'(a);
    req_data  = DATA_W'(d);
    rsp_ready = (stall == 0);
    wait_ready("wr");
    @(posedge CLK_); #1;
    req_valid = 1'b0;
    check("wr_rw_hi", 32'(mem_rw), 32'd1);
    check("wr_addr", 32'(mem_addr), a);
    check("wr_wdata", 32'(mem_wdata), d);
    check("wr_busy", 32'(req_ready), 32'd0);
    check("wr_norsp", 32'(rsp_valid), 32'd0);
    @(posedge CLK_); #1;
    ref_mem[a] = d;
    check("wr_rw_lo", 32'(mem_rw), 32'd0);
    check("wr_hold", 32'(mem_wdata), d);
`ifdef RAM_CTRL_WACK_EN
    check("wack_valid", 32'(rsp_valid), 32'd1);
    check("wack_data", 32'(rsp_data), d);
    check("wack_txn_pre", 32'(txn_count), exp_txn);
    hold_resp(stall, DATA_W'(d));
    @(posedge CLK_); #1;
    exp_txn = (exp_txn + 1) % 256;
    check("wack_done", 32'(rsp_valid), 32'd0);
`else
    exp_txn = (exp_txn + 1) % 256;
    check("wr_norsp2", 32'(rsp_valid), 32'd0);
`endif
    check("wr_txn", 32'(txn_count), exp_txn);
    check("wr_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input int unsigned a, input int stall);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = ADDR_W'(a);
    req_data  = DATA_W'($urandom);
    rsp_ready = (stall == 0);
    wait_ready("rd");
    @(posedge CLK_); #1;
    req_valid = 1'b0;
    check("rd_busy", 32'(req_ready), 32'd0);
    check("rd_norsp", 32'(rsp_valid), 32'd0);
    check("rd_rw", 32'(mem_rw), 32'd0);
    check("rd_addr", 32'(mem_addr), a);
    @(posedge CLK_); #1;
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_data", 32'(rsp_data), ref_mem[a]);
    hold_resp(stall, DATA_W'(ref_mem[a]));
    @(posedge CLK_); #1;
    exp_txn = (exp_txn + 1) % 256;
    check("rd_done", 32'(rsp_valid), 32'd0);
    check("rd_idle", 32'(req_ready), 32'd1);
    check("rd_txn", 32'(txn_count), exp_txn);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rw"}, 32'(mem_rw), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rspd"}, 32'(rsp_data), 32'd0);
    check({tag, "_txn"}, 32'(txn_count), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic apply_reset();
    CLR_ = 1'b0;
    repeat (2) @(posedge CLK_);
    @(negedge CLK_);
    CLR_ = 1'b1;
    @(posedge CLK_); #1;
    exp_txn = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_arr[i] = '0;
      ref_mem[i] = 0;
    end
    exp_txn   = 0;
    CLR_      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #1;
    check_reset_outs("rst");
    apply_reset();
    check_reset_outs("rel");

    // Directed cases.
    do_write(2, 4'hA, 0);
    do_write(1, 4'h5, 2);
    do_read(1, 0);
    do_write(3, 4'h3, 4);
    do_read(1, 5);

    // Reset in the middle of a read.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 2'd2;
    wait_ready("rr");
    @(posedge CLK_); #1;
    req_valid = 1'b0;
    #2;
    CLR_ = 1'b0;
    #1;
    exp_txn = 0;
    check_reset_outs("mid");
    req_valid = 1'b1;
    req_write = 1'b1;
    @(posedge CLK_); #1;
    check("rst_nowr", 32'(mem_rw), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    req_valid = 1'b0;
    @(negedge CLK_);
    CLR_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_); #1;
      check("post_rst_norsp", 32'(rsp_valid), 32'd0);
    end
    do_read(2, 0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_write($urandom_range(DEPTH - 1, 0), $urandom_range(15, 0), $urandom_range(3, 0));
      else
        do_read($urandom_range(DEPTH - 1, 0), $urandom_range(3, 0));
    end

    // 256 back-to-back writes from a clean count.
    apply_reset();
    burst = 1'b1;
    for (int i = 0; i < 256; i++)
      do_write($urandom_range(DEPTH - 1, 0), $urandom_range(15, 0), 0);
    burst = 1'b0;
    check("wrap_txn", 32'(txn_count), 32'd0);
    check("burst_acc", burst_acc, 32'd256);
    check("burst_gap", gap_bad, 32'd0);
    check("rw_consec", rw_consec, 32'd0);
    for (int i = 0; i < DEPTH; i++) do_read(i, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
